// File: rtl/ibex_pkg.sv
// Shared definitions for the LVT-based FPGA register file.
//   rf_state_e : two-state controller encoding (INIT walk, RUN).
//   lvt_width  : number of live-value-table bits needed to name a write
//                port; never less than 1 so the table stays a real signal.
package ibex_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    function automatic int unsigned lvt_width(input int unsigned num_write_ports);
        return (num_write_ports <= 1) ? 1 : $clog2(num_write_ports);
    endfunction

endpackage

// File: rtl/ibex_register_file_lvt_bank.sv
// One RAM bank of the LVT register file.
//   clk   : write clock
//   we    : write enable
//   waddr : write word address
//   wdata : write data
//   raddr : one address per read port (asynchronous reads)
//   rdata : one data word per read port
// No reset and no read registers, so the array maps onto distributed RAM.
module ibex_register_file_lvt_bank #(
    parameter int unsigned NumWords     = 32,
    parameter int unsigned AddrW        = 5,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned NumReadPorts = 2
) (
    input  logic                                    clk,
    input  logic                                    we,
    input  logic [AddrW-1:0]                        waddr,
    input  logic [DataWidth-1:0]                    wdata,
    input  logic [NumReadPorts-1:0][AddrW-1:0]      raddr,
    output logic [NumReadPorts-1:0][DataWidth-1:0]  rdata
);

    logic [DataWidth-1:0] mem [NumWords];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar r = 0; r < NumReadPorts; r++) begin : g_read
        assign rdata[r] = mem[raddr[r]];
    end

endmodule

// File: rtl/ibex_register_file_lvt_fpga.sv
// Multi-write-port register file built from one RAM bank per write port and
// a live-value table (LVT) remembering which bank holds the newest copy of
// each word. After every reset release the controller walks all words,
// writing WordZeroVal to every bank and 0 to the LVT, before accepting writes.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   raddr_i/rdata_o : asynchronous read ports
//   waddr_i/wdata_i/we_i : write ports (port 1 wins on same-address collision)
//   init_done_o : high once the initialisation walk has finished
//   err_o : one-cycle pulse after a collision or an out-of-range RV32E write
//   state_o : current controller state, for observation
//
// Handshake: there is none; we_i is sampled on every rising edge in RUN and
// ignored in INIT, reads are purely combinational.
import ibex_pkg::*;

module ibex_register_file_lvt_fpga #(
    parameter bit                   RV32E         = 1'b0,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumReadPorts  = 2,
    parameter int unsigned          NumWritePorts = 2,
    parameter bit                   WriteBypass   = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [NumReadPorts-1:0][4:0]            raddr_i,
    output logic [NumReadPorts-1:0][DataWidth-1:0]  rdata_o,
    input  logic [NumWritePorts-1:0][4:0]           waddr_i,
    input  logic [NumWritePorts-1:0][DataWidth-1:0] wdata_i,
    input  logic [NumWritePorts-1:0]                we_i,
    output logic                                    init_done_o,
    output logic                                    err_o,
    output rf_state_e                               state_o
);

    localparam int unsigned NUM_WORDS = RV32E ? 16 : 32;
    localparam int unsigned ADDR_W    = RV32E ? 4 : 5;
    localparam int unsigned LVT_W     = lvt_width(NumWritePorts);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

    rf_state_e         state;
    logic [ADDR_W-1:0] walk_cnt;

    // A write that actually lands: RUN, enabled, nonzero, and in range.
    logic [NumWritePorts-1:0] wr_ok;
    logic [NumWritePorts-1:0] wr_bad_addr;
    logic                     collide;
    logic                     err_d;

    always_comb begin
        wr_ok       = '0;
        wr_bad_addr = '0;
        for (int p = 0; p < NumWritePorts; p++) begin
            wr_bad_addr[p] = RV32E && we_i[p] && waddr_i[p][4];
            wr_ok[p]       = (state == RF_RUN) && we_i[p] && (waddr_i[p] != 5'd0)
                             && !(RV32E && waddr_i[p][4]);
        end
    end

    // Index NumWritePorts-1 keeps the expression legal with one port; the
    // constant guard then disables it.
    always_comb begin
        collide = 1'b0;
        if (NumWritePorts == 2) begin
            collide = we_i[0] && we_i[NumWritePorts-1]
                      && (waddr_i[0] == waddr_i[NumWritePorts-1])
                      && (waddr_i[0] != 5'd0);
        end
        err_d = (state == RF_RUN) && (collide || (|wr_bad_addr));
    end

    // Controller: INIT walks every word once, RUN is terminal until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= RF_INIT;
            walk_cnt    <= '0;
            init_done_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o <= err_d;
            case (state)
                RF_INIT: begin
                    walk_cnt <= walk_cnt + 1'b1;
                    if (walk_cnt == LAST_WORD) begin
                        state       <= RF_RUN;
                        init_done_o <= 1'b1;
                    end
                end
                RF_RUN: begin
                    state <= RF_RUN;
                end
                default: begin
                    state <= RF_INIT;
                end
            endcase
        end
    end

    assign state_o = state;

    // Bank write ports: the walk owns every bank during INIT.
    logic [NumWritePorts-1:0]                 bank_we;
    logic [NumWritePorts-1:0][ADDR_W-1:0]     bank_waddr;
    logic [NumWritePorts-1:0][DataWidth-1:0]  bank_wdata;
    logic [NumReadPorts-1:0][ADDR_W-1:0]      bank_raddr;
    logic [NumWritePorts-1:0][NumReadPorts-1:0][DataWidth-1:0] bank_rdata;

    always_comb begin
        for (int p = 0; p < NumWritePorts; p++) begin
            if (state == RF_INIT) begin
                bank_we[p]    = 1'b1;
                bank_waddr[p] = walk_cnt;
                bank_wdata[p] = WordZeroVal;
            end else begin
                bank_we[p]    = wr_ok[p];
                bank_waddr[p] = waddr_i[p][ADDR_W-1:0];
                bank_wdata[p] = wdata_i[p];
            end
        end
        for (int r = 0; r < NumReadPorts; r++) begin
            bank_raddr[r] = raddr_i[r][ADDR_W-1:0];
        end
    end

    for (genvar p = 0; p < NumWritePorts; p++) begin : g_bank
        ibex_register_file_lvt_bank #(
            .NumWords     (NUM_WORDS),
            .AddrW        (ADDR_W),
            .DataWidth    (DataWidth),
            .NumReadPorts (NumReadPorts)
        ) u_bank (
            .clk   (clk_i),
            .we    (bank_we[p]),
            .waddr (bank_waddr[p]),
            .wdata (bank_wdata[p]),
            .raddr (bank_raddr),
            .rdata (bank_rdata[p])
        );
    end

    // Live-value table. Later loop iterations win, so port 1 owns a
    // collided word, matching the bypass priority below.
    logic [LVT_W-1:0] lvt [NUM_WORDS];

    always_ff @(posedge clk_i) begin
        if (state == RF_INIT) begin
            lvt[walk_cnt] <= '0;
        end else begin
            for (int p = 0; p < NumWritePorts; p++) begin
                if (wr_ok[p]) begin
                    lvt[waddr_i[p][ADDR_W-1:0]] <= LVT_W'(p);
                end
            end
        end
    end

    // Read mux: zero in INIT, for x0 and for RV32E out-of-range addresses.
    always_comb begin
        for (int r = 0; r < NumReadPorts; r++) begin
            rdata_o[r] = '0;
            if ((state == RF_RUN) && (raddr_i[r] != 5'd0) && !(RV32E && raddr_i[r][4])) begin
                rdata_o[r] = bank_rdata[lvt[bank_raddr[r]]][r];
                if (WriteBypass) begin
                    for (int p = 0; p < NumWritePorts; p++) begin
                        if (wr_ok[p] && (waddr_i[p] == raddr_i[r])) begin
                            rdata_o[r] = wdata_i[p];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/ibex_register_file_lvt_fpga.md
IBEX_REGISTER_FILE_LVT_FPGA -- requirements
Module: ibex_register_file_lvt_fpga

Interface
REQ-001 SHALL have parameter RV32E, default 0: 1 = 16 words with 4-bit effective address; 0 = 32 words.
REQ-002 SHALL have parameter DataWidth, default 32: word width.
REQ-003 SHALL have parameter NumReadPorts, default 2: asynchronous read ports, legal range 1..4.
REQ-004 SHALL have parameter NumWritePorts, default 2: write ports, legal range 1..2.
REQ-005 SHALL have parameter WriteBypass, default 0: 1 = same-cycle write data forwarded to reads.
REQ-006 SHALL have parameter WordZeroVal, default '0: value every word holds after initialisation.
REQ-007 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port raddr_i, input, NumReadPorts x 5 bits: read addresses.
REQ-010 SHALL have port rdata_o, output, NumReadPorts x DataWidth bits: read data.
REQ-011 SHALL have port waddr_i, input, NumWritePorts x 5 bits: write addresses.
REQ-012 SHALL have port wdata_i, input, NumWritePorts x DataWidth bits: write data.
REQ-013 SHALL have port we_i, input, NumWritePorts bits: write enables.
REQ-014 SHALL have port init_done_o, output, 1 bit: high once the initialisation walk completes.
REQ-015 SHALL have port err_o, output, 1 bit: registered error pulse.

Function
REQ-016 SHALL hold one RAM bank per write port; bank p is written only by port p, and all read ports read every bank.
REQ-017 SHALL keep a live-value table (LVT) in flops, ceil(log2(NumWritePorts)) bits per word, recording which bank last wrote each word.
REQ-018 SHALL run a two-state FSM: INIT -> RUN after the last word is cleared; RUN is terminal until reset.
REQ-019 SHALL, in INIT, clear one word per cycle from address 0 to NUM_WORDS-1 by writing WordZeroVal to all banks and 0 to the LVT, taking exactly NUM_WORDS cycles.
REQ-020 SHALL raise init_done_o on the first RUN cycle.
REQ-021 SHALL ignore all we_i while in INIT.
REQ-022 SHALL return '0 on every rdata_o while in INIT.
REQ-023 SHALL, in RUN, read combinationally: rdata_o[r] = bank[LVT[raddr]][raddr].
REQ-024 SHALL return '0 for any read of address 0.
REQ-025 SHALL, in RUN, perform each write with address != 0 on the rising edge: update its bank word and set LVT[addr] = p.
REQ-026 SHALL, when both ports write the same nonzero address in one cycle, let port 1 win and assert err_o on the next cycle.
REQ-027 SHALL, with RV32E=1, suppress any write with waddr bit 4 set and assert err_o on the next cycle.
REQ-028 SHALL, with RV32E=1, return '0 for any read with raddr bit 4 set.
REQ-029 SHALL, with WriteBypass=1 in RUN, return the winning same-cycle wdata_i for a read whose address matches an enabled nonzero write; with WriteBypass=0, such a read returns the old value.
REQ-030 SHALL hold err_o high for exactly one cycle per offending cycle.

Reset
REQ-031 SHALL, on assertion of rst_ni, immediately and asynchronously reset FSM to INIT, walk counter to 0, init_done_o to 0 and err_o to 0, including mid-walk or mid-write.
REQ-032 SHALL leave RAM banks without reset; the initialisation walk re-clears them after every reset release.

Structure
REQ-033 SHALL place the FSM state enum and the LVT-width function in ibex_pkg.
REQ-034 SHALL implement each bank as sub-module ibex_register_file_lvt_bank: 1 synchronous write port, NumReadPorts asynchronous read ports, no reset, RAM-inferable.

Verification
REQ-035 Reset release, RV32E=0 -> init_done_o low for 32 cycles, high on cycle 33; read of address 5 returns WordZeroVal after the walk.
REQ-036 Port 0 writes 0xDEADBEEF to x3, next cycle port 1 writes 0x12345678 to x3 -> read x3 returns 0x12345678; then port 0 writes 0x1 to x3 -> read returns 0x1.
REQ-037 Both ports write x7 (0xAAAA0000 / 0x5555FFFF) in one cycle -> x7 = 0x5555FFFF, err_o high for one cycle.
REQ-038 WriteBypass=1, write 0xCAFEF00D to x9 while reading x9 in the same cycle -> rdata_o = 0xCAFEF00D in that cycle; WriteBypass=0 -> rdata_o shows the previous value.
REQ-039 Write 0xFFFFFFFF to x0 -> read x0 returns 0, err_o stays low; RV32E=1 write to address 17 -> suppressed, err_o pulses.
REQ-040 Assert rst_ni at walk cycle 10 -> init_done_o stays 0; after release the walk restarts at 0 and completes in NUM_WORDS cycles.
